// File: rtl/rs_chk_pkg.sv
// Shared types and constants for the RS decoder framing/length checker.
package rs_chk_pkg;

   // Framing state, shared by the input-side and output-side trackers.
   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } chk_state_t;

   // Bit positions inside chk_sticky.
   localparam int STK_LEN   = 0;
   localparam int STK_UNDER = 1;
   localparam int STK_OVER  = 2;
   localparam int STK_PROTO = 3;

endpackage

// File: rtl/rs_len_fifo.sv
// DEPTH x CNT_W length FIFO. The head is presented combinationally so a
// one-symbol output frame can be compared in the same cycle it pops.
module rs_len_fifo
   import rs_chk_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [CNT_W-1:0]             din,
   output logic [CNT_W-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [OCC_W-1:0] count_reg;
   logic [OCC_W-1:0] count_next;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_reg == OCC_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign dout  = mem_reg[rd_ptr_reg];

   // A pop frees a slot, so a full FIFO popped and pushed together keeps the push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Occupancy follows accepted pushes and pops only.
   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Storage is never cleared; only pointers and occupancy reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/rs_frame_checker.sv
// Framing and length checker beside the RS decoder: tracks input and output
// codeword framing, queues input lengths and checks each output length.
module rs_frame_checker
   import rs_chk_pkg::*;
#(
   parameter int WORD_LENGTH = 8,
   parameter int N           = 15,
   parameter int K           = 11,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = $clog2(N + 2),
   parameter int STAT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_start_codeword,
   input  logic                         i_end_codeword,
   input  logic                         i_valid,
   input  logic [WORD_LENGTH-1:0]       i_symbol,
   input  logic                         o_in_ready,
   input  logic                         o_start_codeword,
   input  logic                         o_end_codeword,
   input  logic                         o_valid,
   input  logic                         o_error,
   input  logic [WORD_LENGTH-1:0]       o_symbol,
   input  logic                         sticky_clr,
   output logic                         chk_frame_ok,
   output logic                         chk_len_err,
   output logic [3:0]                   chk_sticky,
   output logic [$clog2(DEPTH+1)-1:0]   chk_pending,
   output logic [STAT_W-1:0]            chk_frames_in,
   output logic [STAT_W-1:0]            chk_frames_out,
   output logic [STAT_W-1:0]            chk_err_frames
);

   // Length value meaning "longer than N"; counts saturate here.
   localparam logic [CNT_W-1:0] LEN_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LEN_OVER = CNT_W'(N + 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == LEN_OVER) ? LEN_OVER : c + 1'b1;
   endfunction

   chk_state_t       in_state_reg, in_state_next;
   chk_state_t       out_state_reg, out_state_next;
   logic [CNT_W-1:0] in_cnt_reg, in_cnt_next;
   logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
   logic [CNT_W-1:0] exp_len_reg;
   logic             exp_valid_reg;
   logic             live_reg;
   logic             frame_ok_reg, len_err_reg;
   logic [3:0]       sticky_reg;
   logic [3:0]       sticky_set;
   logic [STAT_W-1:0] frames_in_reg, frames_out_reg, err_frames_reg;

   logic             in_beat, out_beat;
   logic             push, pop, in_proto, out_proto, out_close;
   logic [CNT_W-1:0] push_len, out_len, cmp_len, fifo_dout;
   logic             cmp_valid, len_match, frame_ok_next, len_err_next;
   logic             fifo_full, fifo_empty;
   logic             unused_sym;

   // Symbols and K are carried for interface compatibility only.
   assign unused_sym = ^{i_symbol, o_symbol, (K > 0)};

   // Beats are ignored on the first edge after reset release.
   assign in_beat  = live_reg & i_valid & o_in_ready;
   assign out_beat = live_reg & o_valid;

   // Input framing: count beats and produce a length on every frame close.
   always_comb begin
      in_state_next = in_state_reg;
      in_cnt_next   = in_cnt_reg;
      push          = 1'b0;
      push_len      = LEN_ONE;
      in_proto      = 1'b0;
      if (in_beat) begin
         if (i_start_codeword) begin
            in_proto = (in_state_reg == FRAME);
            if (i_end_codeword) begin
               push          = 1'b1;
               in_state_next = IDLE;
            end else begin
               in_cnt_next   = LEN_ONE;
               in_state_next = FRAME;
            end
         end else if (in_state_reg == IDLE) begin
            in_proto = 1'b1;
         end else if (i_end_codeword) begin
            push          = 1'b1;
            push_len      = sat_inc(in_cnt_reg);
            in_state_next = IDLE;
         end else begin
            in_cnt_next = sat_inc(in_cnt_reg);
         end
      end
   end

   // Output framing: every start pops the expected length, every end closes.
   always_comb begin
      out_state_next = out_state_reg;
      out_cnt_next   = out_cnt_reg;
      pop            = 1'b0;
      out_close      = 1'b0;
      out_len        = LEN_ONE;
      out_proto      = 1'b0;
      if (out_beat) begin
         if (o_start_codeword) begin
            out_proto = (out_state_reg == FRAME);
            pop       = 1'b1;
            if (o_end_codeword) begin
               out_close      = 1'b1;
               out_state_next = IDLE;
            end else begin
               out_cnt_next   = LEN_ONE;
               out_state_next = FRAME;
            end
         end else if (out_state_reg == IDLE) begin
            out_proto = 1'b1;
         end else if (o_end_codeword) begin
            out_close      = 1'b1;
            out_len        = sat_inc(out_cnt_reg);
            out_state_next = IDLE;
         end else begin
            out_cnt_next = sat_inc(out_cnt_reg);
         end
      end
   end

   // Compare against the head just popped (one-beat frame) or the held value.
   // An over-length frame can never be confirmed, so it always mismatches.
   always_comb begin
      cmp_valid     = pop ? ~fifo_empty : exp_valid_reg;
      cmp_len       = pop ? fifo_dout : exp_len_reg;
      len_match     = (out_len == cmp_len) && (cmp_len != LEN_OVER);
      frame_ok_next = out_close & cmp_valid & len_match;
      len_err_next  = out_close & cmp_valid & ~len_match;
   end

   // Events that raise sticky flags this cycle.
   always_comb begin
      sticky_set            = '0;
      sticky_set[STK_PROTO] = in_proto | out_proto
                            | (push & (push_len == LEN_OVER))
                            | (out_close & (out_len == LEN_OVER));
      sticky_set[STK_OVER]  = push & fifo_full & ~pop;
      sticky_set[STK_UNDER] = pop & fifo_empty;
      sticky_set[STK_LEN]   = len_err_next;
   end

   rs_len_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_len_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_len),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (chk_pending)
   );

   // Framing state, expected length, pulses and statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_reg       <= 1'b0;
         in_state_reg   <= IDLE;
         out_state_reg  <= IDLE;
         in_cnt_reg     <= '0;
         out_cnt_reg    <= '0;
         exp_len_reg    <= '0;
         exp_valid_reg  <= 1'b0;
         frame_ok_reg   <= 1'b0;
         len_err_reg    <= 1'b0;
         frames_in_reg  <= '0;
         frames_out_reg <= '0;
         err_frames_reg <= '0;
      end else begin
         live_reg      <= 1'b1;
         in_state_reg  <= in_state_next;
         out_state_reg <= out_state_next;
         in_cnt_reg    <= in_cnt_next;
         out_cnt_reg   <= out_cnt_next;
         if (pop) begin
            exp_len_reg   <= fifo_dout;
            exp_valid_reg <= ~fifo_empty;
         end
         frame_ok_reg   <= frame_ok_next;
         len_err_reg    <= len_err_next;
         frames_in_reg  <= frames_in_reg + {{(STAT_W-1){1'b0}}, push};
         frames_out_reg <= frames_out_reg + {{(STAT_W-1){1'b0}}, out_close};
         err_frames_reg <= err_frames_reg + {{(STAT_W-1){1'b0}}, out_close & o_error};
      end
   end

   // Sticky flags; a clear wins over a set in the same cycle.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sticky
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                 sticky_reg[gi] <= 1'b0;
            else if (sticky_clr)     sticky_reg[gi] <= 1'b0;
            else if (sticky_set[gi]) sticky_reg[gi] <= 1'b1;
         end
      end
   endgenerate

   assign chk_frame_ok   = frame_ok_reg;
   assign chk_len_err    = len_err_reg;
   assign chk_sticky     = sticky_reg;
   assign chk_frames_in  = frames_in_reg;
   assign chk_frames_out = frames_out_reg;
   assign chk_err_frames = err_frames_reg;

endmodule

// File: tb/tb_rs_frame_checker.sv
// Bench for rs_frame_checker: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based reference model.
module tb_rs_frame_checker;

   localparam int WL     = 8;
   localparam int N      = 15;
   localparam int K      = 11;
   localparam int DEPTH  = 4;
   localparam int STAT_W = 16;
   localparam int PEND_W = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_start_codeword = 1'b0, i_end_codeword = 1'b0, i_valid = 1'b0;
   logic [WL-1:0]     i_symbol = '0;
   logic              o_in_ready = 1'b0;
   logic              o_start_codeword = 1'b0, o_end_codeword = 1'b0, o_valid = 1'b0, o_error = 1'b0;
   logic [WL-1:0]     o_symbol = '0;
   logic              sticky_clr = 1'b0;
   logic              chk_frame_ok, chk_len_err;
   logic [3:0]        chk_sticky;
   logic [PEND_W-1:0] chk_pending;
   logic [STAT_W-1:0] chk_frames_in, chk_frames_out, chk_err_frames;

   always #5 clk = ~clk;

   rs_frame_checker #(
      .WORD_LENGTH (WL), .N (N), .K (K), .DEPTH (DEPTH), .STAT_W (STAT_W)
   ) dut (
      .clk (clk), .rst (rst),
      .i_start_codeword (i_start_codeword), .i_end_codeword (i_end_codeword),
      .i_valid (i_valid), .i_symbol (i_symbol), .o_in_ready (o_in_ready),
      .o_start_codeword (o_start_codeword), .o_end_codeword (o_end_codeword),
      .o_valid (o_valid), .o_error (o_error), .o_symbol (o_symbol),
      .sticky_clr (sticky_clr),
      .chk_frame_ok (chk_frame_ok), .chk_len_err (chk_len_err),
      .chk_sticky (chk_sticky), .chk_pending (chk_pending),
      .chk_frames_in (chk_frames_in), .chk_frames_out (chk_frames_out),
      .chk_err_frames (chk_err_frames)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int ok_seen = 0;
   int lerr_seen = 0;

   // Reference model: frame lengths as plain integers in a queue.
   int         m_q[$];
   bit         m_live;
   bit         m_in_open, m_out_open;
   int         m_in_len, m_out_len, m_exp;
   bit         m_ok, m_lerr;
   logic [3:0] m_sticky;
   int         m_fin, m_fout, m_ferr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_live = 0; m_in_open = 0; m_out_open = 0;
      m_in_len = 0; m_out_len = 0; m_exp = -1;
      m_ok = 0; m_lerr = 0; m_sticky = 4'b0000;
      m_fin = 0; m_fout = 0; m_ferr = 0;
   endfunction

   function automatic void model_out_close(input int len);
      m_out_open = 0;
      m_fout++;
      if (o_error) m_ferr++;
      if (len > N) m_sticky[3] = 1'b1;
      if (m_exp >= 0) begin
         if (len == m_exp && len <= N) m_ok = 1;
         else begin
            m_lerr = 1;
            m_sticky[0] = 1'b1;
         end
      end
      $display("[%0t] out frame len=%0d expected=%0d err=%0b", $time, len, m_exp, o_error);
   endfunction

   function automatic void model_edge();
      int push_len;
      push_len = 0;
      if (rst) begin
         model_reset();
         return;
      end
      m_ok = 0; m_lerr = 0;
      if (!m_live) begin
         m_live = 1;
         return;
      end
      if (i_valid && o_in_ready) begin
         if (i_start_codeword) begin
            if (m_in_open) m_sticky[3] = 1'b1;
            if (i_end_codeword) begin push_len = 1; m_in_open = 0; end
            else begin m_in_open = 1; m_in_len = 1; end
         end else if (!m_in_open) begin
            m_sticky[3] = 1'b1;
         end else begin
            m_in_len = (m_in_len > N) ? N + 1 : m_in_len + 1;
            if (i_end_codeword) begin push_len = m_in_len; m_in_open = 0; end
         end
      end
      if (o_valid) begin
         if (o_start_codeword) begin
            if (m_out_open) m_sticky[3] = 1'b1;
            if (m_q.size() > 0) m_exp = m_q.pop_front();
            else begin m_exp = -1; m_sticky[1] = 1'b1; end
            if (o_end_codeword) model_out_close(1);
            else begin m_out_open = 1; m_out_len = 1; end
         end else if (!m_out_open) begin
            m_sticky[3] = 1'b1;
         end else begin
            m_out_len = (m_out_len > N) ? N + 1 : m_out_len + 1;
            if (o_end_codeword) model_out_close(m_out_len);
         end
      end
      // The pop above sees the pre-edge contents; the push lands afterwards.
      if (push_len > 0) begin
         m_fin++;
         if (push_len > N) m_sticky[3] = 1'b1;
         if (m_q.size() < DEPTH) m_q.push_back(push_len);
         else m_sticky[2] = 1'b1;
         $display("[%0t] in  frame len=%0d queued=%0d", $time, push_len, m_q.size());
      end
      if (sticky_clr) m_sticky = 4'b0000;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("frame_ok", 32'(chk_frame_ok), 32'(m_ok));
      chk("len_err", 32'(chk_len_err), 32'(m_lerr));
      chk("sticky", 32'(chk_sticky), 32'(m_sticky));
      chk("pending", 32'(chk_pending), m_q.size());
      chk("frames_in", 32'(chk_frames_in), m_fin & 32'hFFFF);
      chk("frames_out", 32'(chk_frames_out), m_fout & 32'hFFFF);
      chk("err_frames", 32'(chk_err_frames), m_ferr & 32'hFFFF);
      ok_seen   += int'(chk_frame_ok);
      lerr_seen += int'(chk_len_err);
   endtask

   task automatic set_inputs(input bit iv, input bit is, input bit ie,
                             input bit ov, input bit os, input bit oe, input bit oerr);
      i_valid = iv; i_start_codeword = is; i_end_codeword = ie;
      o_in_ready = iv ? 1'b1 : 1'($urandom % 2);
      o_valid = ov; o_start_codeword = os; o_end_codeword = oe; o_error = oerr;
      i_symbol = WL'($urandom); o_symbol = WL'($urandom);
   endtask

   task automatic beat(input bit iv, input bit is, input bit ie,
                       input bit ov, input bit os, input bit oe, input bit oerr);
      set_inputs(iv, is, ie, ov, os, oe, oerr);
      step();
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) beat(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic in_frame(input int len);
      for (int b = 0; b < len; b++) beat(1, b == 0, b == len - 1, 0, 0, 0, 0);
   endtask

   task automatic out_frame(input int len, input bit err);
      for (int b = 0; b < len; b++) beat(0, 0, 0, 1, b == 0, b == len - 1, err);
   endtask

   task automatic do_reset();
      set_inputs(0, 0, 0, 0, 0, 0, 0);
      sticky_clr = 0;
      rst = 1; step(); step();
      rst = 0; step(); step();
      ok_seen = 0; lerr_seen = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ok"}, 32'(chk_frame_ok), 0);
      chk({tag, "_lerr"}, 32'(chk_len_err), 0);
      chk({tag, "_sticky"}, 32'(chk_sticky), 0);
      chk({tag, "_pending"}, 32'(chk_pending), 0);
      chk({tag, "_fin"}, 32'(chk_frames_in), 0);
      chk({tag, "_fout"}, 32'(chk_frames_out), 0);
      chk({tag, "_ferr"}, 32'(chk_err_frames), 0);
   endtask

   initial begin
      int in_rem, out_rem;
      model_reset();
      do_reset();
      chk_all_zero("reset");

      // Three matching 15-symbol frame pairs.
      for (int f = 0; f < 3; f++) in_frame(15);
      for (int f = 0; f < 3; f++) out_frame(15, 0);
      chk("s1_ok_pulses", ok_seen, 3);
      chk("s1_frames_in", 32'(chk_frames_in), 3);
      chk("s1_frames_out", 32'(chk_frames_out), 3);
      chk("s1_sticky", 32'(chk_sticky), 0);
      chk("s1_pending", 32'(chk_pending), 0);

      // Short output frame.
      do_reset();
      in_frame(15);
      out_frame(14, 0);
      chk("s2_len_err", lerr_seen, 1);
      chk("s2_sticky", 32'(chk_sticky), 32'b0001);

      // Overflow with DEPTH=4.
      do_reset();
      for (int f = 0; f < 5; f++) in_frame(15);
      chk("s3_pending", 32'(chk_pending), 4);
      chk("s3_sticky", 32'(chk_sticky), 32'b0100);
      chk("s3_frames_in", 32'(chk_frames_in), 5);

      // Underflow, then a push alongside the second pop (no bypass: push is kept).
      do_reset();
      beat(0, 0, 0, 1, 1, 1, 0);
      chk("s4_under1", 32'(chk_sticky), 32'b0010);
      sticky_clr = 1; idle(1); sticky_clr = 0;
      chk("s4_cleared", 32'(chk_sticky), 0);
      beat(1, 1, 0, 0, 0, 0, 0);
      beat(1, 0, 1, 1, 1, 1, 0);
      chk("s4_under2", 32'(chk_sticky), 32'b0010);
      chk("s4_no_pulse", ok_seen + lerr_seen, 0);
      chk("s4_pending", 32'(chk_pending), 1);

      // Stray beat, then an over-length 17-beat frame pair.
      do_reset();
      beat(1, 0, 0, 0, 0, 0, 0);
      chk("s5_proto", 32'(chk_sticky), 32'b1000);
      in_frame(17);
      chk("s5_pending", 32'(chk_pending), 1);
      out_frame(17, 1);
      chk("s5_len_err", lerr_seen, 1);
      chk("s5_sticky", 32'(chk_sticky), 32'b1001);
      chk("s5_err_frames", 32'(chk_err_frames), 1);

      // Asynchronous reset mid-frame with two lengths queued.
      do_reset();
      in_frame(15); in_frame(15);
      chk("s6_pending", 32'(chk_pending), 2);
      beat(1, 1, 0, 0, 0, 0, 0);
      for (int b = 0; b < 4; b++) beat(1, 0, 0, 0, 0, 0, 0);
      set_inputs(0, 0, 0, 0, 0, 0, 0);
      rst = 1;
      #2;
      chk_all_zero("async_rst");
      model_reset();
      step();
      rst = 0; step(); step();
      sticky_clr = 1; step(); sticky_clr = 0;
      chk_all_zero("s6_after");
      ok_seen = 0;
      in_frame(15);
      out_frame(15, 0);
      chk("s6_ok", ok_seen, 1);
      chk("s6_frames_out", 32'(chk_frames_out), 1);

      // Randomized traffic with occasional protocol violations.
      do_reset();
      in_rem = 0; out_rem = 0;
      for (int c = 0; c < 1500; c++) begin
         i_valid = ($urandom % 4) != 0;
         o_in_ready = ($urandom % 5) != 0;
         i_start_codeword = 0; i_end_codeword = 0;
         i_symbol = WL'($urandom); o_symbol = WL'($urandom);
         if (i_valid && o_in_ready) begin
            if (in_rem == 0 && ($urandom % 12) == 0) begin
               i_end_codeword = 1'($urandom % 2);
            end else begin
               if (in_rem == 0 || ($urandom % 40) == 0) begin
                  i_start_codeword = 1;
                  in_rem = $urandom_range(1, N + 2);
               end
               i_end_codeword = (in_rem == 1);
               in_rem--;
            end
         end
         o_valid = 0; o_start_codeword = 0; o_end_codeword = 0;
         o_error = ($urandom % 4) == 0;
         if (($urandom % 3) != 0) begin
            if (out_rem == 0) begin
               if (m_q.size() > 0 || ($urandom % 10) == 0) begin
                  o_valid = 1; o_start_codeword = 1;
                  out_rem = (m_q.size() > 0 && ($urandom % 4) != 0) ? m_q[0]
                                                                    : $urandom_range(1, N + 2);
               end else if (($urandom % 15) == 0) begin
                  o_valid = 1;
               end
            end else begin
               o_valid = 1;
               if (($urandom % 40) == 0) begin
                  o_start_codeword = 1;
                  out_rem = $urandom_range(1, N + 2);
               end
            end
            if (o_valid && out_rem > 0) begin
               o_end_codeword = (out_rem == 1);
               out_rem--;
            end
         end
         sticky_clr = ($urandom % 60) == 0;
         step();
      end
      sticky_clr = 0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
